// File: rtl/interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// interrupt_arbiter
//
// Purpose:
//   Collects three asynchronous interrupt lines. Each line is synchronised
//   and edge-detected, then latched as a pending event. The block picks the
//   highest-priority unmasked pending source and allows nesting: a new source
//   is requested only if it outranks everything currently in service. A
//   single held request is presented to the pipeline control unit. In-service
//   levels are tracked, and the highest one is retired on every ERET.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous reset, active low
//   irq_in    in   [2:0] raw async interrupt lines, bit 2 = highest priority
//   irq_mask  in   [2:0] 1 = source masked
//   ie        in   global interrupt enable
//   int_ack   in   1-cycle pulse, pipeline took the interrupt this cycle
//   eret      in   1-cycle pulse, ERET retired this cycle
//   int_req   out  interrupt request to control unit
//   int_id    out  [2:0] requested source, 1/2/3 = irq_in[0]/[1]/[2], 0 = none
//   irs       out  [2:0] in-service bits, one per source
//   pending   out  [2:0] latched pending bits
// ---------------------------------------------------------------------------
module interrupt_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] irq_in,
  input  logic [2:0] irq_mask,
  input  logic       ie,
  input  logic       int_ack,
  input  logic       eret,
  output logic       int_req,
  output logic [2:0] int_id,
  output logic [2:0] irs,
  output logic [2:0] pending
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e     state_q;
  logic       intReq_q;
  logic [2:0] intId_q;

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] syncPrev_q;
  logic [2:0] pending_q, pending_d;
  logic [2:0] irs_q, irs_d;

  logic [2:0] rise;
  logic [2:0] avail;
  logic       candValid;
  logic [1:0] candIdx;
  logic       irsTopValid;
  logic [1:0] irsTopIdx;
  logic       eligible;
  logic       ackTake;
  logic [1:0] reqIdx;

  // Synchroniser chain plus one extra flop on its output.
  // The extra flop lets a held level produce exactly one rise event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      syncPrev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      syncPrev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = sync_q[SYNC_STAGES-1] & ~syncPrev_q;
  assign avail = pending_q & ~irq_mask;

  // Find the highest available source and the highest in-service level.
  // The loops scan upward, so the last hit found is the highest one.
  always_comb begin
    candValid   = 1'b0;
    candIdx     = 2'd0;
    irsTopValid = 1'b0;
    irsTopIdx   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (avail[i]) begin
        candValid = 1'b1;
        candIdx   = 2'(i);
      end
      if (irs_q[i]) begin
        irsTopValid = 1'b1;
        irsTopIdx   = 2'(i);
      end
    end
  end

  // Only strict preemption is allowed. An equal or lower level waits until
  // the in-service stack drains below it.
  assign eligible = ie & candValid & (~irsTopValid | (candIdx > irsTopIdx));
  assign ackTake  = (state_q == REQ) & int_ack;
  assign reqIdx   = intId_q[1:0] - 2'd1;

  // ERET retires the highest pre-edge level before the ack marks its source.
  // A rise detected in the same cycle as an ack re-sets the pending bit, so a
  // new event is never lost.
  always_comb begin
    pending_d = pending_q;
    irs_d     = irs_q;
    if (ackTake) begin
      pending_d[reqIdx] = 1'b0;
    end
    pending_d = pending_d | rise;
    if (eret && irsTopValid) begin
      irs_d[irsTopIdx] = 1'b0;
    end
    if (ackTake) begin
      irs_d[reqIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      irs_q     <= '0;
    end else begin
      pending_q <= pending_d;
      irs_q     <= irs_d;
    end
  end

  // Request FSM with registered outputs. Once in REQ, the id is frozen until
  // an ack or a withdrawal (ie dropped). The ack takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      intReq_q <= 1'b0;
      intId_q  <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible) begin
            state_q  <= REQ;
            intReq_q <= 1'b1;
            intId_q  <= {1'b0, candIdx} + 3'd1;
          end else begin
            intReq_q <= 1'b0;
            intId_q  <= 3'd0;
          end
        end
        REQ: begin
          if (int_ack || !ie) begin
            state_q  <= IDLE;
            intReq_q <= 1'b0;
            intId_q  <= 3'd0;
          end
        end
        default: begin
          state_q  <= IDLE;
          intReq_q <= 1'b0;
          intId_q  <= 3'd0;
        end
      endcase
    end
  end

  assign int_req = intReq_q;
  assign int_id  = intId_q;
  assign irs     = irs_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_interrupt_arbiter
//
// Purpose:
//   Drives interrupt_arbiter with a directed single-source start, then long
//   randomized traffic and an asynchronous reset taken while a request is
//   held. Every cycle the outputs are compared with a reference model.
//
//   The model works with these abstractions:
//     - the sampled history of irq_in, for event detection;
//     - a queue of in-service ids, used as a nesting stack;
//     - the pending events;
//     - the currently held request.
// ---------------------------------------------------------------------------
module tb_interrupt_arbiter;

  localparam int S = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] irq_in;
  logic [2:0] irq_mask;
  logic       ie;
  logic       int_ack;
  logic       eret;
  logic       int_req;
  logic [2:0] int_id;
  logic [2:0] irs;
  logic [2:0] pending;

  int checkCount = 0;
  int errorCount = 0;

  interrupt_arbiter #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .irq_mask (irq_mask),
    .ie       (ie),
    .int_ack  (int_ack),
    .eret     (eret),
    .int_req  (int_req),
    .int_id   (int_id),
    .irs      (irs),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit [2:0] hist [S+1];
  int       mStack[$];
  bit [2:0] mPend;
  bit       mReq;
  int       mId;

  bit [2:0] ev;
  bit       ackTake;
  int       cand;
  int       oldTop;
  bit       nextReq;
  int       nextId;

  function automatic bit [2:0] stackBits();
    bit [2:0] b = '0;
    foreach (mStack[k]) b[mStack[k]-1] = 1'b1;
    return b;
  endfunction

  // Cycle model. An input event is the 0->1 step in the sample history that
  // is S edges old. An ack moves the held id onto the in-service stack, and
  // an ERET pops the top of that stack first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= S; j++) hist[j] = '0;
      mStack.delete();
      mPend = '0;
      mReq  = 1'b0;
      mId   = 0;
    end else begin
      ev = hist[S-1] & ~hist[S];
      for (int j = S; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = irq_in;

      ackTake = mReq && int_ack;
      oldTop  = (mStack.size() > 0) ? mStack[$] : 0;
      cand    = -1;
      for (int i = 0; i < 3; i++) begin
        if (mPend[i] && !irq_mask[i]) cand = i;
      end

      if (mReq) begin
        nextReq = !(int_ack || !ie);
        nextId  = nextReq ? mId : 0;
      end else if (ie && cand >= 0 && (cand + 1) > oldTop) begin
        nextReq = 1'b1;
        nextId  = cand + 1;
      end else begin
        nextReq = 1'b0;
        nextId  = 0;
      end

      if (eret && mStack.size() > 0) void'(mStack.pop_back());
      if (ackTake) mStack.push_back(mId);
      if (ackTake) mPend[mId-1] = 1'b0;
      mPend = mPend | ev;

      mReq = nextReq;
      mId  = nextId;
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time,
               observed, expected);
    end
  endtask

  task automatic compareAll();
    checkOutput("int_req", 8'(int_req), 8'(mReq));
    checkOutput("int_id",  8'(int_id),  8'(mId));
    checkOutput("irs",     8'(irs),     8'(stackBits()));
    checkOutput("pending", 8'(pending), 8'(mPend));
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      compareAll();
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(5) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(19) == 0) irq_mask = ($urandom_range(2) == 0) ? 3'($urandom) : 3'b000;
      ie      = ($urandom_range(11) != 0);
      int_ack = ($urandom_range(2) == 0);
      eret    = ($urandom_range(7) == 0);
    end
  endtask

  initial begin
    bit gotReq;
    rst_n    = 1'b0;
    irq_in   = '0;
    irq_mask = '0;
    ie       = 1'b0;
    int_ack  = 1'b0;
    eret     = 1'b0;
    repeat (3) @(negedge clk);
    compareAll();
    checkOutput("rst_int_req", 8'(int_req), 8'd0);

    // Single source: the line is held high, the request is acked once, and
    // no second event follows.
    rst_n  = 1'b1;
    ie     = 1'b1;
    irq_in = 3'b001;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      compareAll();
      int_ack = (c == 6);
    end
    checkOutput("single_irs", 8'(irs), 8'h01);

    applyStimulus(4000);

    // Asynchronous reset taken while a request is held.
    irq_mask = '0;
    ie       = 1'b1;
    int_ack  = 1'b0;
    eret     = 1'b0;
    gotReq   = 1'b0;
    for (int c = 0; c < 300 && !gotReq; c++) begin
      @(negedge clk);
      compareAll();
      if (mReq) gotReq = 1'b1;
      else irq_in = 3'($urandom);
    end
    checkOutput("req_before_reset", 8'(int_req), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", 8'(int_req), 8'd0);
    checkOutput("async_rst_id",  8'(int_id),  8'd0);
    checkOutput("async_rst_irs", 8'(irs),     8'd0);
    checkOutput("async_rst_pnd", 8'(pending), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1500);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
